// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready, shifts them out MSB-first
// on `a`, appends GAP idle zeros, and counts the "110" sequences it has driven.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [$clog2(WIDTH+1)-1:0] load_len,
    output logic                       a,
    output logic                       busy,
    output logic                       done,
    output logic                       exp_w,
    output logic [CNT_W-1:0]           hits
);

    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int GAP_W = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        h;
    logic [WIDTH-1:0]  shreg_p1;
    logic [LEN_W-1:0]  len_p0;
    logic [WIDTH-1:0]  aligned_p0;
    logic              vld_p0;
    logic              hit_now;

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || int'(len) > WIDTH) begin
            return LEN_W'(WIDTH);
        end
        return len;
    endfunction

    // Stage p0: left-justify the word so its first bit sits at the top of the shift register
    assign len_p0     = eff_len(load_len);
    assign aligned_p0 = load_data << (LEN_W'(WIDTH) - len_p0);
    assign vld_p0     = load_valid && (state == ST_IDLE);

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign hit_now    = (h == 2'b11) && !a;

    // Stage p1: datapath shift register, deliberately left without reset
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            shreg_p1 <= aligned_p0 << 1;
        end else if (state == ST_SHIFT) begin
            shreg_p1 <= shreg_p1 << 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            a       <= 1'b0;
            done    <= 1'b0;
            exp_w   <= 1'b0;
            hits    <= '0;
            h       <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            done  <= 1'b0;
            h     <= {h[0], a};
            exp_w <= hit_now;
            if (hit_now) begin
                hits <= hits + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (vld_p0) begin
                        a       <= aligned_p0[WIDTH-1];
                        bit_cnt <= len_p0 - LEN_W'(1);
                        state   <= ST_SHIFT;
                    end else begin
                        a <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == '0) begin
                        a <= 1'b0;
                        if (GAP > 0) begin
                            gap_cnt <= GAP_W'(GAP > 0 ? GAP - 1 : 0);
                            state   <= ST_GAP;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        a       <= shreg_p1[WIDTH-1];
                        bit_cnt <= bit_cnt - LEN_W'(1);
                    end
                end
                ST_GAP: begin
                    a <= 1'b0;
                    if (gap_cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    a     <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
